efpga_apb_lint_bridge: RTL

- Converts SoC APB slave accesses to the eFPGA Type-1 register window into single-outstanding LINT (XBAR_TCDM-style) transactions.
- Sits directly upstream of the eFPGA subsystem's apbt1_i slave port, in the asic_clk_i domain.
- Guards the SoC against a hung or unprogrammed fabric with a request/response timeout, reporting PSLVERR and flushing late responses.

---
 rtl/efpga_apb_lint_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/efpga_apb_lint_bridge.sv
// APB slave to single-outstanding LINT master bridge for the eFPGA Type-1 window.
// A request/response timeout returns PSLVERR and flushes a late fabric response.
module efpga_apb_lint_bridge #(
    parameter int APB_ADDR_WIDTH      = 32,
    parameter int APB_FPGA_ADDR_WIDTH = 20,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int ERR_CNT_WIDTH       = 8
) (
    input  logic                      asic_clk_i,
    input  logic                      rst_n,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      lint_req_o,
    output logic [31:0]               lint_add_o,
    output logic                      lint_wen_o,
    output logic [3:0]                lint_be_o,
    output logic [31:0]               lint_wdata_o,
    input  logic                      lint_gnt_i,
    input  logic                      lint_r_valid_i,
    input  logic [31:0]               lint_r_rdata_i,
    output logic                      busy_o,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o,
    input  logic                      err_clr_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE,
        ST_FLUSH
    } state_t;

    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ERR_RDATA = 32'hDEAD_BEEF;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [CNT_W-1:0]               r_cnt;
    logic [CNT_W-1:0]               w_cnt_next;
    logic [APB_FPGA_ADDR_WIDTH-3:0] r_addr;
    logic [31:0]                    r_wdata;
    logic                           r_write;
    logic                           r_pready;
    logic                           w_pready_next;
    logic                           r_pslverr;
    logic                           w_pslverr_next;
    logic [31:0]                    r_prdata;
    logic [31:0]                    w_prdata_next;
    logic [ERR_CNT_WIDTH-1:0]       r_err_cnt;
    logic                           w_capture;
    logic                           w_expire;
    logic                           w_cnt_last;
    logic                           w_unused;

    // A grant taken on the last allowed cycle pushes the counter past CNT_LAST,
    // so the deadline test must be >= to still fire in the following RSP cycle.
    assign w_cnt_last = (r_cnt >= CNT_LAST);
    assign w_unused   = ^{penable_i, paddr_i[APB_ADDR_WIDTH-1:APB_FPGA_ADDR_WIDTH], paddr_i[1:0]};

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pready_next  = 1'b0;
        w_pslverr_next = 1'b0;
        w_prdata_next  = 32'h0;
        w_capture      = 1'b0;
        w_expire       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_pready high means the master is still in the access phase of
                // the transfer just answered, so its psel must not start a new one.
                if (psel_i && !r_pready) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (lint_gnt_i) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (lint_r_valid_i) begin
                        w_state_next  = ST_DONE;
                        w_pready_next = 1'b1;
                        w_prdata_next = r_write ? 32'h0 : lint_r_rdata_i;
                    end else begin
                        w_state_next = ST_RSP;
                    end
                end else if (w_cnt_last) begin
                    w_expire       = 1'b1;
                    w_state_next   = ST_IDLE;
                    w_pready_next  = 1'b1;
                    w_pslverr_next = 1'b1;
                    w_prdata_next  = ERR_RDATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RSP: begin
                if (lint_r_valid_i) begin
                    w_state_next  = ST_DONE;
                    w_pready_next = 1'b1;
                    w_prdata_next = r_write ? 32'h0 : lint_r_rdata_i;
                end else if (w_cnt_last) begin
                    w_expire       = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = ST_FLUSH;
                    w_pready_next  = 1'b1;
                    w_pslverr_next = 1'b1;
                    w_prdata_next  = ERR_RDATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                if (lint_r_valid_i || w_cnt_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge asic_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= 32'h0;
            r_write   <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= 32'h0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pready  <= w_pready_next;
            r_pslverr <= w_pslverr_next;
            r_prdata  <= w_prdata_next;
            if (w_capture) begin
                r_addr  <= paddr_i[APB_FPGA_ADDR_WIDTH-1:2];
                r_wdata <= pwdata_i;
                r_write <= pwrite_i;
            end
            if (w_expire) begin
                if (err_clr_i) begin
                    r_err_cnt <= ERR_CNT_WIDTH'(1);
                end else if (!(&r_err_cnt)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (err_clr_i) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign prdata_o     = r_prdata;
    assign pready_o     = r_pready;
    assign pslverr_o    = r_pslverr;
    assign lint_req_o   = (r_state == ST_REQ);
    assign lint_add_o   = 32'({r_addr, 2'b00});
    assign lint_wen_o   = (r_state == ST_REQ) ? ~r_write : 1'b1;
    assign lint_be_o    = (r_state == ST_REQ) ? 4'hF : 4'h0;
    assign lint_wdata_o = r_wdata;
    assign busy_o       = (r_state != ST_IDLE);
    assign err_cnt_o    = r_err_cnt;

endmodule
